// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred_taken;
    logic [31:0] pred_target;
  } fetch_entry_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
  } inflight_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two output buffer between instruction fetch and IF/ID, with total flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  fetch_entry_t               push_data_i,
  input  logic                       pop_i,
  output fetch_entry_t               head_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  fetch_entry_t  mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries data only; occupancy is tracked by the control registers above.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= push_data_i;
  end

  assign valid_o = (count_q != '0);
  assign head_o  = valid_o ? mem_q[rd_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues 1-cycle imem reads, buffers tagged results.
// Optional build macro FETCH_PERF_EN adds saturating issue/redirect/stall counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] bp_pc,
  input  logic        bp_predict_taken,
  input  logic [31:0] bp_next_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_pred_taken,
  output logic [31:0] out_pred_target
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_issued,
  output logic [31:0] perf_redirects,
  output logic [31:0] perf_stall_cycles
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   pc_q;
  inflight_t     slot_q;
  logic [CW-1:0] count;
  logic          pop, push, issue;
  logic [31:0]   occ, lim;
  fetch_entry_t  push_data, head;

  assign pop = out_valid & out_ready;

  // Credit rule: the slot being issued must have a guaranteed FIFO seat when it returns.
  assign occ   = 32'(count) + 32'(slot_q.valid);
  assign lim   = 32'(FIFO_DEPTH) + 32'(pop);
  assign issue = rst_n & ~redirect_valid & (occ < lim);

  assign bp_pc     = pc_q;
  assign imem_addr = pc_q;
  assign imem_req  = issue;

  assign push      = slot_q.valid & ~redirect_valid;
  assign push_data = '{pc: slot_q.pc, instr: imem_rdata,
                       pred_taken: slot_q.pred_taken, pred_target: slot_q.pred_target};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      slot_q <= '0;
    end else if (redirect_valid) begin
      pc_q         <= redirect_pc;
      slot_q.valid <= 1'b0;
    end else if (issue) begin
      pc_q   <= bp_next_pc;
      slot_q <= '{valid: 1'b1, pc: pc_q, pred_taken: bp_predict_taken, pred_target: bp_next_pc};
    end else begin
      slot_q.valid <= 1'b0;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (redirect_valid),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .valid_o     (out_valid),
    .count_o     (count)
  );

  assign out_pc          = head.pc;
  assign out_instr       = head.instr;
  assign out_pred_taken  = head.pred_taken;
  assign out_pred_target = head.pred_target;

`ifdef FETCH_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] perf_issued_q, perf_redirects_q, perf_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued_q    <= '0;
      perf_redirects_q <= '0;
      perf_stall_q     <= '0;
    end else begin
      if (issue)                    perf_issued_q    <= sat_inc(perf_issued_q);
      if (redirect_valid)           perf_redirects_q <= sat_inc(perf_redirects_q);
      if (!issue && !redirect_valid) perf_stall_q    <= sat_inc(perf_stall_q);
    end
  end

  assign perf_issued       = perf_issued_q;
  assign perf_redirects    = perf_redirects_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule
